block_dispatcher: RTL

- Kernel-level controller that splits a launch of thread_count threads into blocks of THREADS_PER_BLOCK and hands them to NUM_CORES compute cores.
- Per core it generates core_reset, core_start, block id and thread count, and watches the core's done flag.
- It recycles finished cores and raises done once every block has completed.
- It sits between the device control register and the per-core schedulers.

---
 rtl/block_dispatcher.sv | 131 +++++++++++++
 1 files changed

// File: rtl/block_dispatcher.sv
// Splits a kernel launch into fixed-size thread blocks and hands them to compute cores,
// recycling each core once it reports done; raises done when every block has completed.
module block_dispatcher #(
    parameter int NUM_CORES = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int COUNT_W = 8,
    localparam int TC_W = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [COUNT_W-1:0]           thread_count,
    input  logic [NUM_CORES-1:0]         core_done,
    output logic [NUM_CORES-1:0]         core_reset,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES*COUNT_W-1:0] core_block_id,
    output logic [NUM_CORES*TC_W-1:0]    core_thread_count,
    output logic                         done
);
    localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam logic [COUNT_W:0] BLK_ONE = 1;
    localparam logic [COUNT_W:0] TPB_M1 = THREADS_PER_BLOCK - 1;
    localparam logic [TC_W-1:0] FULL_TC = THREADS_PER_BLOCK;

    typedef enum logic [1:0] {TOP_IDLE, TOP_DISPATCH, TOP_DONE} top_state_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_RESET, SLOT_RUN, SLOT_RELEASE} slot_state_t;

    top_state_t          top_q, top_d;
    slot_state_t         slot_q [NUM_CORES];
    slot_state_t         slot_d [NUM_CORES];
    logic [COUNT_W-1:0]  tc_q;
    logic [COUNT_W:0]    total_q, dispatched_q, completed_q;
    logic [COUNT_W:0]    total_calc, release_cnt;
    logic [COUNT_W-1:0]  block_id_q [NUM_CORES];
    logic [TC_W-1:0]     block_tc_q [NUM_CORES];
    logic [NUM_CORES-1:0] pick;
    logic [TPB_LOG2-1:0] remainder;
    logic [TC_W-1:0]     next_tc;
    logic                launch, can_dispatch, last_block;

    // Block count is computed one bit wider so a full-range thread_count cannot overflow.
    assign launch       = (top_q == TOP_IDLE) && start;
    assign total_calc   = ({1'b0, thread_count} + TPB_M1) >> TPB_LOG2;
    assign can_dispatch = (top_q == TOP_DISPATCH) && (dispatched_q < total_q);
    assign remainder    = tc_q[TPB_LOG2-1:0];
    assign last_block   = (dispatched_q == total_q - BLK_ONE);
    assign next_tc      = (last_block && remainder != '0) ? {1'b0, remainder} : FULL_TC;

    always_comb begin
        top_d = top_q;
        case (top_q)
            TOP_IDLE:     if (start) top_d = TOP_DISPATCH;
            TOP_DISPATCH: if (completed_q == total_q) top_d = TOP_DONE;
            TOP_DONE:     top_d = TOP_DONE;
            default:      top_d = TOP_IDLE;
        endcase
    end

    // Lowest-index FREE slot wins; a slot leaving RELEASE is only FREE from the next cycle.
    always_comb begin
        pick        = '0;
        release_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                SLOT_FREE: begin
                    if (can_dispatch && pick == '0) begin
                        pick[i]   = 1'b1;
                        slot_d[i] = SLOT_RESET;
                    end
                end
                SLOT_RESET:   slot_d[i] = SLOT_RUN;
                SLOT_RUN:     if (core_done[i]) slot_d[i] = SLOT_RELEASE;
                SLOT_RELEASE: begin
                    slot_d[i]   = SLOT_FREE;
                    release_cnt = release_cnt + BLK_ONE;
                end
                default:      slot_d[i] = SLOT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q        <= TOP_IDLE;
            tc_q         <= '0;
            total_q      <= '0;
            dispatched_q <= '0;
            completed_q  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_q[i]     <= SLOT_FREE;
                block_id_q[i] <= '0;
                block_tc_q[i] <= '0;
            end
        end else begin
            top_q <= top_d;
            if (launch) begin
                tc_q         <= thread_count;
                total_q      <= total_calc;
                dispatched_q <= '0;
                completed_q  <= '0;
            end else begin
                if (pick != '0) dispatched_q <= dispatched_q + BLK_ONE;
                completed_q <= completed_q + release_cnt;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_q[i] <= slot_d[i];
                if (pick[i]) begin
                    block_id_q[i] <= dispatched_q[COUNT_W-1:0];
                    block_tc_q[i] <= next_tc;
                end
            end
        end
    end

    always_comb begin
        core_reset        = '0;
        core_start        = '0;
        core_block_id     = '0;
        core_thread_count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_reset[i] = (slot_q[i] == SLOT_RESET) || (slot_q[i] == SLOT_RELEASE);
            core_start[i] = (slot_q[i] == SLOT_RUN);
            core_block_id[i*COUNT_W +: COUNT_W]  = block_id_q[i];
            core_thread_count[i*TC_W +: TC_W]    = block_tc_q[i];
        end
    end

    assign done = (top_q == TOP_DONE);

endmodule
